sample_gatherer: RTL and testbench

Serial-to-parallel front end for the eight-input averaging datapath. Accepts one 16-bit sample per valid/ready beat plus a per-frame shift amount, and assembles eight consecutive samples into lanes a..h. Presents the complete frame on stable registered outputs with its own valid/ready handshake, so the averager reads a coherent operand set. It is the producer end of the averager's operand interface.

---
 rtl/sample_gatherer_pkg.sv | 18 +
 rtl/sample_lane.sv | 24 ++
 rtl/sample_gatherer.sv | 112 +++++++++++
 tb/tb_sample_gatherer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sample_gatherer_pkg.sv
// Shared constants and types for the sample gatherer and its averager.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sample_gatherer_pkg;

    // Widths shared with the averager's operand interface.
    localparam int DATAWIDTH_DEF = 16;
    localparam int SHWIDTH_DEF   = 8;

    localparam int NUM_LANES  = 8;
    localparam int LANE_IDX_W = 3;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/sample_lane.sv
// Load-enable register with synchronous active-low reset (one operand lane).
// Latency: q updates on the clock edge where ld is high.
// Backpressure: none; the caller decides when to load.
//
// Ports: clk, rst_n (sync, active-low), ld (load enable), d (data in), q (held value).
module sample_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sample_gatherer.sv
// Gathers eight serial samples into lanes a..h and presents them as one frame.
// Latency: out_valid rises on the edge that accepts beat 7; frame held until consumed.
// Backpressure: in_ready drops while a frame is held (FULL) or reset is asserted.
//
// Ports: Clk, Rst (sync active-low); in_data/in_sh_amt/in_valid/in_ready input beat
// handshake; a..h/sh_amt/out_valid/out_ready frame handshake; count = beats so far.
module sample_gatherer
    import sample_gatherer_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int SHWIDTH   = SHWIDTH_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATAWIDTH-1:0]  in_data,
    input  logic [SHWIDTH-1:0]    in_sh_amt,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATAWIDTH-1:0]  a,
    output logic [DATAWIDTH-1:0]  b,
    output logic [DATAWIDTH-1:0]  c,
    output logic [DATAWIDTH-1:0]  d,
    output logic [DATAWIDTH-1:0]  e,
    output logic [DATAWIDTH-1:0]  f,
    output logic [DATAWIDTH-1:0]  g,
    output logic [DATAWIDTH-1:0]  h,
    output logic [SHWIDTH-1:0]    sh_amt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANE_IDX_W-1:0] count
);

    state_t                state, state_nxt;
    logic [LANE_IDX_W-1:0] count_nxt;
    logic                  beat_acc;
    logic [NUM_LANES-1:0]  lane_ld;
    logic [DATAWIDTH-1:0]  lane_q [NUM_LANES];

    // Rst gates in_ready so no beat is taken in the reset cycle itself.
    assign in_ready  = (state == FILL) && Rst;
    assign beat_acc  = in_valid && in_ready;
    assign out_valid = (state == FULL);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= FILL;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            FILL: begin
                if (beat_acc) begin
                    // 3-bit counter wraps 7 -> 0 as the frame completes.
                    count_nxt = count + 1'b1;
                    if (count == LANE_IDX_W'(NUM_LANES - 1)) begin
                        state_nxt = FULL;
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // One-hot lane select: only the lane addressed by count loads.
    always_comb begin
        lane_ld = '0;
        if (beat_acc) begin
            lane_ld[count] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sample_lane #(.W(DATAWIDTH)) u_lane (
            .clk   (Clk),
            .rst_n (Rst),
            .ld    (lane_ld[i]),
            .d     (in_data),
            .q     (lane_q[i])
        );
    end

    // Shift amount belongs to the frame, so it is taken with beat 0 only.
    sample_lane #(.W(SHWIDTH)) u_sh (
        .clk   (Clk),
        .rst_n (Rst),
        .ld    (lane_ld[0]),
        .d     (in_sh_amt),
        .q     (sh_amt)
    );

    assign a = lane_q[0];
    assign b = lane_q[1];
    assign c = lane_q[2];
    assign d = lane_q[3];
    assign e = lane_q[4];
    assign f = lane_q[5];
    assign g = lane_q[6];
    assign h = lane_q[7];

endmodule

// File: tb/tb_sample_gatherer.sv
module tb_sample_gatherer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] in_data;
    logic [7:0]  in_sh_amt;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  sh_amt;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;

    always #5 Clk = ~Clk;

    sample_gatherer dut (
        .Clk(Clk), .Rst(Rst),
        .in_data(in_data), .in_sh_amt(in_sh_amt), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .sh_amt(sh_amt), .out_valid(out_valid), .out_ready(out_ready), .count(count)
    );

    logic [15:0] lanes [8];
    assign lanes[0] = a; assign lanes[1] = b; assign lanes[2] = c; assign lanes[3] = d;
    assign lanes[4] = e; assign lanes[5] = f; assign lanes[6] = g; assign lanes[7] = h;

    int errors = 0;
    int checks = 0;

    // Reference: a frame is a list of collected samples; full once it holds eight.
    logic [15:0] m_frame [8];
    int          m_have;     // samples collected toward the next frame
    bit          m_full;
    logic [7:0]  m_sh;

    // Streaming bookkeeping.
    int cyc_idx;
    int pulses;
    int first_pulse;
    int last_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_frame[i] = '0;
        m_have = 0;
        m_full = 0;
        m_sh   = '0;
    endtask

    task automatic check_state();
        for (int i = 0; i < 8; i++) chk($sformatf("lane%0d", i), {16'h0, lanes[i]}, {16'h0, m_frame[i]});
        chk("sh_amt", {24'h0, sh_amt}, {24'h0, m_sh});
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_full});
        chk("count", {29'h0, count}, m_have);
    endtask

    // One clock: drive inputs, check in_ready, clock, advance model, check outputs.
    task automatic cyc(input logic v, input logic [15:0] dat, input logic [7:0] sh,
                       input logic ordy, input logic rst_n);
        bit take;
        in_valid  = v;
        in_data   = dat;
        in_sh_amt = sh;
        out_ready = ordy;
        Rst       = rst_n;
        #1;
        chk("in_ready", {31'h0, in_ready}, {31'h0, (!m_full && rst_n)});
        take = rst_n && !m_full && v;
        @(posedge Clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else if (m_full) begin
            if (ordy) m_full = 0;
        end else if (take) begin
            if (m_have == 0) m_sh = sh;
            m_frame[m_have] = dat;
            m_have++;
            if (m_have == 8) begin
                m_have = 0;
                m_full = 1;
            end
        end
        check_state();
    endtask

    initial begin
        in_valid = 0; in_data = '0; in_sh_amt = '0; out_ready = 0; Rst = 0;
        model_reset();

        // Reset: in_ready must be 0 while Rst is low, everything zero.
        cyc(0, 16'h0, 8'h0, 0, 0);
        cyc(0, 16'h0, 8'h0, 0, 0);
        chk("rst_a", {16'h0, a}, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);

        // Basic frame 1..8, sh 3 on beat 0 and 7 elsewhere.
        for (int i = 0; i < 8; i++) cyc(1, 16'(i + 1), (i == 0) ? 8'd3 : 8'd7, 0, 1);
        chk("basic_a", {16'h0, a}, 32'd1);
        chk("basic_h", {16'h0, h}, 32'd8);
        chk("basic_sh", {24'h0, sh_amt}, 32'd3);
        chk("basic_valid", {31'h0, out_valid}, 32'd1);
        // Held for five cycles while input keeps pushing.
        for (int i = 0; i < 5; i++) cyc(1, 16'hFFFF, 8'hEE, 0, 1);
        chk("held_ready", {31'h0, in_ready}, 32'd0);

        // Consume with in_valid high: beat must not be accepted.
        cyc(1, 16'hFFFF, 8'hEE, 1, 1);
        chk("consume_a", {16'h0, a}, 32'd1);
        chk("consume_valid", {31'h0, out_valid}, 32'd0);
        cyc(1, 16'h0055, 8'h21, 0, 1);
        chk("next_beat_a", {16'h0, a}, 32'h55);
        for (int i = 1; i < 8; i++) cyc(1, 16'h0055 + 16'(i), 8'h0, 0, 1);
        cyc(0, 16'h0, 8'h0, 1, 1);

        // Bubbles: valid every other cycle.
        for (int i = 0; i < 16; i++) cyc((i % 2) == 0, 16'h0010 + 16'(i / 2), 8'h5, 0, 1);
        chk("bubble_a", {16'h0, a}, 32'h10);
        chk("bubble_h", {16'h0, h}, 32'h17);
        chk("bubble_valid", {31'h0, out_valid}, 32'd1);
        cyc(0, 16'h0, 8'h0, 1, 1);

        // Reset mid-frame after five beats.
        for (int i = 0; i < 5; i++) cyc(1, 16'h0BB0 + 16'(i), 8'h9, 0, 1);
        cyc(1, 16'h1234, 8'h1, 0, 0);
        chk("midrst_count", {29'h0, count}, 32'd0);
        chk("midrst_a", {16'h0, a}, 32'd0);
        for (int i = 0; i < 8; i++) cyc(1, 16'hA000 + 16'(i), 8'h4, 0, 1);
        chk("after_rst_b", {16'h0, b}, 32'hA001);
        chk("after_rst_h", {16'h0, h}, 32'hA007);

        // Reset in FULL coinciding with out_ready: reset wins.
        cyc(0, 16'h0, 8'h0, 1, 0);
        chk("fullrst_valid", {31'h0, out_valid}, 32'd0);
        chk("fullrst_d", {16'h0, d}, 32'd0);

        // Streaming: out_ready tied high, three frames.
        pulses = 0; first_pulse = -1; last_pulse = -1;
        for (int i = 0; i < 27; i++) begin
            cyc(1, 16'($urandom), 8'(i / 9 + 1), 1, 1);
            if (out_valid) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
                last_pulse = i;
            end
        end
        chk("stream_pulses", pulses, 32'd3);
        chk("stream_first", first_pulse, 32'd7);
        chk("stream_span", last_pulse - first_pulse, 32'd18);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
